// File: rtl/sd_status_ctrl_pkg.sv
// Shared constants and types for the SD socket status controller.
package sd_status_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;

  localparam int unsigned BIT_WP = 0;
  localparam int unsigned BIT_CD = 1;

  typedef enum logic {
    ST_STABLE,
    ST_CHANGING
  } db_state_e;

endpackage

// File: rtl/sd_status_ctrl_debounce.sv
// Two-flop synchronizer followed by a stable-window debounce FSM for one pin.
module sd_debounce
  import sd_status_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic stable_out,
  output logic change_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_e        state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
      state_q  <= ST_STABLE;
    end else begin
      sync1_q  <= raw_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  // change_pulse is combinational so the edge register sets on the same
  // clock edge that the stable value toggles.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stable_d     = stable_q;
    change_pulse = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync2_q != stable_q) begin
          cnt_d   = '0;
          state_d = ST_CHANGING;
        end
      end
      ST_CHANGING: begin
        if (sync2_q == stable_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          stable_d     = ~stable_q;
          change_pulse = 1'b1;
          state_d      = ST_STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  assign stable_out = stable_q;

endmodule

// File: rtl/sd_status_ctrl.sv
// Avalon-MM status/edge/irq registers for the SD socket pins and write-grant arbiter.
module sd_status_ctrl
  import sd_status_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        wp_n_in,
  input  logic        cd_n_in,
  input  logic        wr_req,
  output logic        wr_grant
);

  logic        wp, cd, wp_chg, cd_chg;
  logic [1:0]  mask_q, mask_d;
  logic [1:0]  edge_q, edge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, grant_q;
  logic        wr_en;
  logic [1:0]  edge_set, edge_clr;
  logic        unused_wdata;

  sd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .RESET_VAL      (1'b1)
  ) u_db_wp (
    .clk         (clk),
    .reset_n     (reset_n),
    .raw_in      (~wp_n_in),
    .stable_out  (wp),
    .change_pulse(wp_chg)
  );

  sd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .RESET_VAL      (1'b0)
  ) u_db_cd (
    .clk         (clk),
    .reset_n     (reset_n),
    .raw_in      (~cd_n_in),
    .stable_out  (cd),
    .change_pulse(cd_chg)
  );

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:2];

  always_comb begin
    mask_d   = mask_q;
    edge_set = '0;
    edge_clr = '0;
    rdata_d  = rdata_q;

    if (wr_en && address == ADDR_MASK) mask_d = writedata[1:0];
    if (wr_en && address == ADDR_EDGE) edge_clr = writedata[1:0];

    edge_set[BIT_WP] = wp_chg;
    edge_set[BIT_CD] = cd_chg;
    // Set is OR'd in after the clear so a coincident edge survives.
    edge_d = (edge_q & ~edge_clr) | edge_set;

    if (chipselect) begin
      rdata_d = '0;
      case (address)
        ADDR_STATUS: begin
          rdata_d[BIT_WP] = wp;
          rdata_d[BIT_CD] = cd;
        end
        ADDR_MASK: rdata_d[1:0] = mask_q;
        ADDR_EDGE: rdata_d[1:0] = edge_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      edge_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      rdata_q <= rdata_d;
      irq_q   <= |(edge_q & mask_q);
      grant_q <= wr_req & cd & ~wp;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;
  assign wr_grant = grant_q;

endmodule

// File: tb/tb_sd_status_ctrl.sv
// Directed bench for sd_status_ctrl with an 8-cycle debounce window.
module tb_sd_status_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        wp_n_in;
  logic        cd_n_in;
  logic        wr_req;
  logic        wr_grant;

  int total = 0;
  int bad   = 0;

  sd_status_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .wp_n_in   (wp_n_in),
    .cd_n_in   (cd_n_in),
    .wr_req    (wr_req),
    .wr_grant  (wr_grant)
  );

  always #5 clk = ~clk;

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_n = 1'b0;
    wp_n_in = 1'b1;
    cd_n_in = 1'b0;
    #12;
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL reset_grant got=%b exp=0", wr_grant); end
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd0, r);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL reset_status_default got=%h exp=%h", r, 32'h1); end
    bus_read(2'd1, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=%h", r, 32'h0); end
    wait_neg(12);
    bus_read(2'd0, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL post_reset_status got=%h exp=%h", r, 32'h2); end
    bus_read(2'd2, r);
    total++; if (r !== 32'h3) begin bad++; $display("FAIL post_reset_edge got=%h exp=%h", r, 32'h3); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL masked_irq got=%b exp=0", irq); end
    bus_write(2'd2, 32'h3);
    bus_read(2'd2, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL edge_clear got=%h exp=%h", r, 32'h0); end
  endtask

  task automatic test_glitch();
    logic [31:0] r;
    wp_n_in = 1'b0;
    wait_neg(5);
    wp_n_in = 1'b1;
    wait_neg(15);
    bus_read(2'd0, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL glitch_status got=%h exp=%h", r, 32'h2); end
    bus_read(2'd2, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL glitch_edge got=%h exp=%h", r, 32'h0); end
  endtask

  task automatic test_irq();
    logic [31:0] r;
    bus_write(2'd1, 32'h2);
    cd_n_in = 1'b1;
    wait_neg(20);
    bus_read(2'd2, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL cd_edge got=%h exp=%h", r, 32'h2); end
    bus_read(2'd0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL cd_removed_status got=%h exp=%h", r, 32'h0); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq); end
    bus_write(2'd2, 32'h2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_lag got=%b exp=1", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] r;
    cd_n_in = 1'b0;
    wait_neg(10);
    bus_write(2'd2, 32'h2);
    bus_read(2'd2, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL collision_edge got=%h exp=%h", r, 32'h2); end
    bus_read(2'd0, r);
    total++; if (r !== 32'h2) begin bad++; $display("FAIL collision_status got=%h exp=%h", r, 32'h2); end
  endtask

  task automatic test_grant();
    wr_req = 1'b1;
    total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL grant_pre got=%b exp=0", wr_grant); end
    @(negedge clk);
    total++; if (wr_grant !== 1'b1) begin bad++; $display("FAIL grant_rise got=%b exp=1", wr_grant); end
    wr_req = 1'b0;
    @(negedge clk);
    total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL grant_req_drop got=%b exp=0", wr_grant); end
    wr_req = 1'b1;
    @(negedge clk);
    total++; if (wr_grant !== 1'b1) begin bad++; $display("FAIL grant_rerise got=%b exp=1", wr_grant); end
    wp_n_in = 1'b0;
    wait_neg(11);
    total++; if (wr_grant !== 1'b1) begin bad++; $display("FAIL grant_hold got=%b exp=1", wr_grant); end
    @(negedge clk);
    total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL grant_wp_drop got=%b exp=0", wr_grant); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    bus_read(2'd0, r);
    total++; if (r !== 32'h3) begin bad++; $display("FAIL protected_status got=%h exp=%h", r, 32'h3); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    cd_n_in = 1'b1;
    wait_neg(7);
    reset_n = 1'b0;
    wp_n_in = 1'b1;
    #1;
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL mid_reset_readdata got=%h exp=%h", readdata, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_reset_irq got=%b exp=0", irq); end
    total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL mid_reset_grant got=%b exp=0", wr_grant); end
    @(negedge clk);
    reset_n = 1'b1;
    wait_neg(10);
    bus_read(2'd0, r);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL restart_before got=%h exp=%h", r, 32'h1); end
    bus_read(2'd0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL restart_after got=%h exp=%h", r, 32'h0); end
    bus_read(2'd2, r);
    total++; if (r !== 32'h1) begin bad++; $display("FAIL restart_edge got=%h exp=%h", r, 32'h1); end
    total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL no_card_grant got=%b exp=0", wr_grant); end
  endtask

  task automatic test_unused_addr();
    logic [31:0] r;
    wr_req = 1'b0;
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL addr3_read got=%h exp=%h", r, 32'h0); end
    bus_read(2'd1, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL addr3_no_alias got=%h exp=%h", r, 32'h0); end
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, r);
    total++; if (r !== 32'h3) begin bad++; $display("FAIL mask_all_ones got=%h exp=%h", r, 32'h3); end
    chipselect = 1'b0;
    address    = 2'd0;
    wait_neg(2);
    total++; if (readdata !== 32'h3) begin bad++; $display("FAIL readdata_hold got=%h exp=%h", readdata, 32'h3); end
  endtask

  initial begin
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    wr_req     = 1'b0;
    test_reset();
    test_glitch();
    test_irq();
    test_collision();
    test_grant();
    test_reset_mid();
    test_unused_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
